pc_sequencer: RTL and testbench

Program-counter sequencer for the MIPS-FPGA core. It owns the PC register and runs a fetch/execute handshake loop with instruction memory and the execute datapath. It computes the next PC internally as sequential (PC+1), conditional-branch (PC+1 plus a signed offset when branch and zero are both set), or absolute jump. It also keeps a retired-instruction count for debug.

---
 rtl/pc_sequencer.sv | 141 ++++++++++++++
 tb/tb_pc_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, runs the fetch/execute handshake
// with instruction memory and the datapath, and counts retired instructions.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | stopped; PC held, waiting for start (halt wins over start)
// S_FETCH | imem_req high, waiting for imem_ack (unbounded wait)
// S_EXEC  | instruction issued, waiting for ex_done to retire it
module pc_sequencer #(
   parameter int              PC_W     = 6,
   parameter int              OFF_W    = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             halt,
   output logic             imem_req,
   output logic [PC_W-1:0]  imem_addr,
   input  logic             imem_ack,
   output logic             instr_valid,
   input  logic             ex_done,
   input  logic             branch,
   input  logic             zero,
   input  logic             jump,
   input  logic [OFF_W-1:0] offset,
   input  logic [PC_W-1:0]  jump_target,
   output logic [PC_W-1:0]  pc,
   output logic             running,
   output logic             branch_taken,
   output logic [CNT_W-1:0] retired
);

   localparam int SUM_W = PC_W + OFF_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              halt_pending;
   logic              retire;
   logic              redirect;
   logic [PC_W-1:0]   seq_pc;
   logic [PC_W-1:0]   next_pc;
   logic [SUM_W-1:0]  off_ext;
   logic [SUM_W-1:0]  br_sum;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and state-decoded outputs; reset clears imem_req
   // combinationally since it is decoded from the async-reset state.
   always_comb begin
      state_nxt = state;
      retire    = 1'b0;
      imem_req  = 1'b0;
      running   = 1'b1;
      case (state)
         S_IDLE: begin
            running = 1'b0;
            if (start && !halt) begin
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (ex_done) begin
               retire    = 1'b1;
               state_nxt = (halt_pending || halt) ? S_IDLE : S_FETCH;
            end
         end
         default: begin
            running   = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Next-PC selection: jump beats branch; the branch sum is formed wide and
   // truncated so the offset wraps modulo 2^PC_W.
   always_comb begin
      seq_pc   = pc + PC_W'(1);
      off_ext  = {{PC_W{offset[OFF_W-1]}}, offset};
      br_sum   = {{OFF_W{1'b0}}, seq_pc} + off_ext;
      redirect = jump || (branch && zero);
      if (jump) begin
         next_pc = jump_target;
      end else if (branch && zero) begin
         next_pc = br_sum[PC_W-1:0];
      end else begin
         next_pc = seq_pc;
      end
   end

   // PC and retired counter update only when an instruction retires.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc      <= RESET_PC;
         retired <= '0;
      end else if (retire) begin
         pc      <= next_pc;
         retired <= retired + CNT_W'(1);
      end
   end

   // Registered pulses and the sticky halt request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_valid  <= 1'b0;
         branch_taken <= 1'b0;
         halt_pending <= 1'b0;
      end else begin
         instr_valid  <= (state == S_FETCH) && imem_ack;
         branch_taken <= retire && redirect;
         if (state != S_IDLE && state_nxt == S_IDLE) begin
            halt_pending <= 1'b0;
         end else if ((state == S_FETCH || state == S_EXEC) && halt) begin
            halt_pending <= 1'b1;
         end
      end
   end

   assign imem_addr = pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus a randomized instruction
// stream, checked against a reference that tracks PC and retire count.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        halt = 1'b0;
   logic        imem_req;
   logic [5:0]  imem_addr;
   logic        imem_ack = 1'b0;
   logic        instr_valid;
   logic        ex_done = 1'b0;
   logic        branch = 1'b0;
   logic        zero = 1'b0;
   logic        jump = 1'b0;
   logic [7:0]  offset = 8'd0;
   logic [5:0]  jump_target = 6'd0;
   logic [5:0]  pc;
   logic        running;
   logic        branch_taken;
   logic [15:0] retired;

   int n_checks = 0;
   int n_errors = 0;
   int exp_pc   = 0;
   int exp_ret  = 0;

   pc_sequencer #(.PC_W(6), .OFF_W(8), .RESET_PC(6'd0), .CNT_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .halt         (halt),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .instr_valid  (instr_valid),
      .ex_done      (ex_done),
      .branch       (branch),
      .zero         (zero),
      .jump         (jump),
      .offset       (offset),
      .jump_target  (jump_target),
      .pc           (pc),
      .running      (running),
      .branch_taken (branch_taken),
      .retired      (retired)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0; halt = 1'b0; imem_ack = 1'b0; ex_done = 1'b0;
      branch = 1'b0; zero = 1'b0; jump = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      exp_pc = 0;
      exp_ret = 0;
   endtask

   // Leave IDLE; called at a negedge with the sequencer idle.
   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_req", imem_req, 1);
      check("start_run", running, 1);
      check("start_addr", imem_addr, exp_pc);
   endtask

   // Runs one instruction starting in the first FETCH cycle; returns with
   // the sequencer in FETCH or IDLE, one negedge after the retire edge.
   // hmode: 0 no halt, 1 halt pulse in first FETCH cycle, 2 halt with ex_done.
   task automatic run_instr(input int ack_wait, input int ex_wait,
                            input logic br, input logic z, input logic jp,
                            input logic [7:0] off, input logic [5:0] tgt,
                            input int hmode, output logic halted);
      int   npc;
      logic tk;
      logic hp;
      hp = 1'b0;
      check("fetch_req", imem_req, 1);
      check("fetch_addr", imem_addr, exp_pc);
      for (int i = 0; i < ack_wait; i++) begin
         imem_ack = 1'b0;
         ex_done  = 1'($urandom_range(0, 1));
         halt     = (hmode == 1 && i == 0);
         if (halt) hp = 1'b1;
         @(negedge clk);
         halt = 1'b0;
         check("wait_req", imem_req, 1);
         check("wait_addr", imem_addr, exp_pc);
         check("wait_iv", instr_valid, 0);
         check("wait_bt", branch_taken, 0);
      end
      imem_ack = 1'b1;
      ex_done  = 1'($urandom_range(0, 1));
      halt     = (hmode == 1 && ack_wait == 0);
      if (halt) hp = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      check("exec_iv", instr_valid, 1);
      check("exec_req", imem_req, 0);
      check("exec_bt", branch_taken, 0);
      check("exec_pc", pc, exp_pc);
      for (int i = 0; i < ex_wait; i++) begin
         ex_done  = 1'b0;
         imem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("exwait_iv", instr_valid, 0);
         check("exwait_pc", pc, exp_pc);
         check("exwait_run", running, 1);
      end
      imem_ack = 1'b0;
      ex_done = 1'b1; branch = br; zero = z; jump = jp;
      offset = off; jump_target = tgt;
      halt = (hmode == 2);
      if (halt) hp = 1'b1;
      @(negedge clk);
      ex_done = 1'b0; halt = 1'b0;
      branch = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
      jump = 1'($urandom_range(0, 1));
      if (jp) npc = int'(tgt);
      else if (br && z) npc = (exp_pc + 1 + int'($signed(off))) & 63;
      else npc = (exp_pc + 1) & 63;
      tk = jp | (br & z);
      exp_pc  = npc;
      exp_ret = (exp_ret + 1) & 16'hFFFF;
      check("ret_pc", pc, exp_pc);
      check("ret_cnt", retired, exp_ret);
      check("ret_bt", branch_taken, tk);
      check("ret_run", running, !hp);
      check("ret_req", imem_req, !hp);
      halted = hp;
   endtask

   task automatic jump_to(input int t);
      logic h;
      run_instr(0, 0, 1'b0, 1'b0, 1'b1, 8'd0, 6'(t), 0, h);
   endtask

   initial begin
      logic h;
      do_reset();
      check("rst_pc", pc, 0);
      check("rst_ret", retired, 0);
      check("rst_req", imem_req, 0);
      check("rst_run", running, 0);
      check("rst_iv", instr_valid, 0);
      check("rst_bt", branch_taken, 0);
      @(negedge clk);
      check("idle_hold_req", imem_req, 0);

      // Sequential run at full throughput.
      do_start();
      for (int i = 0; i < 3; i++) begin
         run_instr(0, 0, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0, 0, h);
         check("seq_pc", pc, i + 1);
      end
      check("seq_retired", retired, 3);

      // Branch taken / not taken, wrap cases, priority.
      jump_to(15);
      run_instr(0, 1, 1'b1, 1'b1, 1'b0, 8'd9, 6'd0, 0, h);
      check("br_taken_pc", pc, 25);
      jump_to(15);
      run_instr(0, 0, 1'b1, 1'b0, 1'b0, 8'd9, 6'd0, 0, h);
      check("br_not_taken_pc", pc, 16);
      jump_to(2);
      run_instr(1, 0, 1'b1, 1'b1, 1'b0, 8'hF8, 6'd0, 0, h);
      check("wrap_neg_pc", pc, 59);
      jump_to(62);
      run_instr(0, 0, 1'b1, 1'b1, 1'b0, 8'd4, 6'd0, 0, h);
      check("wrap_pos_pc", pc, 3);
      jump_to(63);
      run_instr(0, 0, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0, 0, h);
      check("wrap_seq_pc", pc, 0);
      jump_to(10);
      run_instr(0, 0, 1'b1, 1'b1, 1'b1, 8'd5, 6'd40, 0, h);
      check("prio_pc", pc, 40);

      // Halt mid-fetch, ack 3 cycles later.
      run_instr(3, 1, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0, 1, h);
      check("halt_pc", pc, 41);
      check("halt_flag", h, 1);
      start = 1'b1; halt = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0; halt = 1'b0;
      check("start_halt_idle", running, 0);
      check("start_halt_req", imem_req, 0);
      do_start();
      check("resume_addr", imem_addr, 41);

      // Randomized instruction stream.
      for (int n = 0; n < 250; n++) begin
         int   aw, ew, hm, r;
         logic rb, rz, rj;
         aw = $urandom_range(0, 3);
         ew = $urandom_range(0, 3);
         rj = ($urandom_range(0, 7) == 0);
         rb = ($urandom_range(0, 2) == 0);
         rz = 1'($urandom_range(0, 1));
         r  = $urandom_range(0, 15);
         hm = (r == 0) ? 1 : (r == 1) ? 2 : 0;
         run_instr(aw, ew, rb, rz, rj, 8'($urandom), 6'($urandom), hm, h);
         if (h) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            check("rnd_idle_pc", pc, exp_pc);
            do_start();
         end
      end

      // Reset in EXEC with pc=20: must take effect before the next edge.
      jump_to(20);
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      check("pre_rst_pc", pc, 20);
      check("pre_rst_iv", instr_valid, 1);
      #1 reset = 1'b1;
      #1;
      check("rst_exec_req", imem_req, 0);
      check("rst_exec_run", running, 0);
      check("rst_exec_pc", pc, 0);
      check("rst_exec_ret", retired, 0);
      @(negedge clk);
      reset = 1'b0;
      exp_pc = 0; exp_ret = 0;

      // Reset in FETCH drops imem_req without a clock edge.
      do_start();
      #1 reset = 1'b1;
      #1;
      check("rst_fetch_req", imem_req, 0);
      @(negedge clk);
      reset = 1'b0;
      check("rst_fetch_pc", pc, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
